// File: rtl/ca_generation_controller.sv
// ca_generation_controller: load/step/free-run sequencer for the cellular automaton array
module ca_generation_controller #(
  parameter int N         = 16,
  parameter int GEN_WIDTH = 16,
  parameter int DIV_WIDTH = 24,
  parameter int DIV_COUNT = 12000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_btn,
  input  logic                 step_btn,
  input  logic                 run_btn,
  input  logic [GEN_WIDTH-1:0] max_gens,
  input  logic [N-1:0]         ca_state,
  output logic                 ca_load,
  output logic                 ca_advance,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic [1:0]           ctrl_state,
  output logic                 stable
);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, HALT = 2'b11} state_t;
  state_t               state;
  logic                 load_q, run_q, step_q, check_pending;
  logic [N-1:0]         snapshot;
  logic [DIV_WIDTH-1:0] div;
  logic                 load_e, run_e, step_e, div_tc, now_stable, hit_limit, halt_now, gen_adv;
  logic [GEN_WIDTH-1:0] gen_inc;

  assign load_e     = load_btn & ~load_q;
  assign run_e      = run_btn & ~run_q;
  assign step_e     = step_btn & ~step_q;
  assign gen_adv    = ca_advance & ~ca_load;
  assign gen_inc    = &gen_count ? gen_count : gen_count + 1'b1;
  assign div_tc     = div == DIV_WIDTH'(DIV_COUNT - 1);
  assign now_stable = check_pending && ca_state == snapshot;
  assign hit_limit  = gen_adv && max_gens != '0 && gen_inc == max_gens;
  assign halt_now   = now_stable | hit_limit;
  assign ctrl_state = state;

  // Sequencer: button edges, generation bookkeeping, fixed-point check and run-rate divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      load_q        <= 1'b0;
      run_q         <= 1'b0;
      step_q        <= 1'b0;
      check_pending <= 1'b0;
      snapshot      <= '0;
      div           <= '0;
      ca_load       <= 1'b0;
      ca_advance    <= 1'b0;
      gen_count     <= '0;
      stable        <= 1'b0;
    end else begin
      load_q     <= load_btn;
      run_q      <= run_btn;
      step_q     <= step_btn;
      ca_load    <= 1'b0;
      ca_advance <= 1'b0;
      if (gen_adv) begin
        gen_count     <= gen_inc;
        snapshot      <= ca_state;
        check_pending <= 1'b1;
      end else if (check_pending) begin
        stable        <= now_stable;
        check_pending <= 1'b0;
      end
      case (state)
        LOAD: begin
          state         <= IDLE;
          gen_count     <= '0;
          stable        <= 1'b0;
          check_pending <= 1'b0;
        end
        IDLE: begin
          if (load_e) begin
            state      <= LOAD;
            ca_load    <= 1'b1;
            ca_advance <= 1'b1;
          end else if (halt_now) state <= HALT;
          else if (run_e) begin
            state <= RUN;
            div   <= '0;
          end else if (step_e) ca_advance <= 1'b1;
        end
        RUN: begin
          if (load_e) begin
            state      <= LOAD;
            ca_load    <= 1'b1;
            ca_advance <= 1'b1;
          end else if (halt_now) state <= HALT;
          else if (run_e) state <= IDLE;
          else begin
            div        <= div_tc ? '0 : div + 1'b1;
            ca_advance <= div_tc;
          end
        end
        HALT: begin
          if (load_e) begin
            state      <= LOAD;
            ca_load    <= 1'b1;
            ca_advance <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ca_generation_controller.sv
// tb_ca_generation_controller: randomized scoreboard bench with a cycle-schedule reference model
module tb_ca_generation_controller;
  localparam int GW = 8;
  localparam int DC = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;

  logic          clk = 1'b0, reset = 1'b1;
  logic          load_btn = 1'b0, step_btn = 1'b0, run_btn = 1'b0;
  logic [GW-1:0] max_gens = '0;
  logic [15:0]   ca_state = 16'h1234;
  logic          ca_load, ca_advance, stable;
  logic [GW-1:0] gen_count;
  logic [1:0]    ctrl_state;

  ca_generation_controller #(.N(16), .GEN_WIDTH(GW), .DIV_WIDTH(24), .DIV_COUNT(DC)) dut (
    .clk(clk), .reset(reset), .load_btn(load_btn), .step_btn(step_btn), .run_btn(run_btn),
    .max_gens(max_gens), .ca_state(ca_state), .ca_load(ca_load), .ca_advance(ca_advance),
    .gen_count(gen_count), .ctrl_state(ctrl_state), .stable(stable)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp, mon_act;

  // environment view of the array: what the controller asked for on the last edge
  logic adv_seen = 1'b0, ld_seen = 1'b0;
  always @(posedge clk) begin
    adv_seen <= ca_advance;
    ld_seen  <= ca_load;
  end

  // monitor: every cycle the DUT presents one status word, compared with the model's prediction
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {ctrl_state, gen_count, stable, ca_advance, ca_load};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL status t=%0t ctrl/gen/stable/adv/load got %0d/%0d/%0b/%0b/%0b expected %0d/%0d/%0b/%0b/%0b",
                 $time, mon_act[12:11], mon_act[10:3], mon_act[2], mon_act[1], mon_act[0],
                 mon_exp[12:11], mon_exp[10:3], mon_exp[2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  // reference model state
  int     m_mode, m_gens, nl, freeze_after;
  bit     m_stab, m_adv, m_ld, pl, pr, ps;
  longint cyc, next_adv, chk_cyc;
  logic [15:0] snap;

  task automatic model_init();
    m_mode = M_IDLE; m_gens = 0; m_stab = 0; m_adv = 0; m_ld = 0;
    pl = 0; pr = 0; ps = 0; chk_cyc = -1; next_adv = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock cycle: the array reacts, buttons are driven, and the next cycle's outputs are predicted
  task automatic step(input bit l, input bit r, input bit s);
    bit le, re, se, adv_now, lim, stb;
    @(negedge clk);
    if (adv_seen) begin
      if (ld_seen) begin
        ca_state = 16'($urandom);
        nl = 0;
      end else begin
        if (nl < freeze_after) ca_state = ca_state ^ 16'($urandom_range(1, 65535));
        nl++;
      end
    end
    load_btn = l; run_btn = r; step_btn = s;
    le = l && !pl; re = r && !pr; se = s && !ps;
    pl = l; pr = r; ps = s;
    adv_now = m_adv && !m_ld;
    if (adv_now) m_gens = (m_gens == 255) ? 255 : m_gens + 1;
    lim = adv_now && max_gens != 0 && m_gens == int'(max_gens);
    stb = (chk_cyc == cyc) && (ca_state == snap);
    if (chk_cyc == cyc) m_stab = stb;
    if (adv_now) begin
      snap = ca_state;
      chk_cyc = cyc + 1;
    end
    m_adv = 0; m_ld = 0;
    if (m_mode == M_LOAD) begin
      m_mode = M_IDLE; m_gens = 0; m_stab = 0; chk_cyc = -1;
    end else if (le) begin
      m_mode = M_LOAD; m_adv = 1; m_ld = 1;
    end else if ((lim || stb) && m_mode != M_HALT) m_mode = M_HALT;
    else if (m_mode == M_IDLE) begin
      if (re) begin
        m_mode = M_RUN;
        next_adv = cyc + 1 + DC;
      end else if (se) m_adv = 1;
    end else if (m_mode == M_RUN) begin
      if (re) m_mode = M_IDLE;
      else if (cyc + 1 == next_adv) begin
        m_adv = 1;
        next_adv += DC;
      end
    end
    exp_q.push_back({2'(m_mode), 8'(m_gens), m_stab, m_adv, m_ld});
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic press(input bit l, input bit r, input bit s);
    step(l, r, s);
    step(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {ctrl_state, gen_count, stable, ca_advance, ca_load}, 0);
    exp_q.delete();
    model_init();
    load_btn = 0; run_btn = 0; step_btn = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    cyc = 0; nl = 0; freeze_after = 1000;
    model_init();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ctrl_state, gen_count, stable, ca_advance, ca_load}, 0);
    reset = 1'b0;
    // load, then three single steps on a changing pattern
    press(1, 0, 0);
    idle(2);
    chk("gen_after_load", int'(gen_count), 0);
    repeat (3) begin
      press(0, 0, 1);
      idle(1);
    end
    idle(2);
    chk("gen_after_3_steps", int'(gen_count), 3);
    // free run to a generation limit of 5, then ignored run/step edges
    press(1, 0, 0);
    max_gens = 8'd5;
    press(0, 1, 0);
    idle(30);
    press(0, 1, 0);
    press(0, 0, 1);
    idle(6);
    chk("limit_gen", int'(gen_count), 5);
    chk("limit_ctrl", int'(ctrl_state), M_HALT);
    // pattern freezes on the second advance
    max_gens = 8'd0;
    freeze_after = 1;
    press(1, 0, 0);
    press(0, 1, 0);
    idle(16);
    chk("fixed_point_gen", int'(gen_count), 2);
    chk("fixed_point_ctrl", int'(ctrl_state), M_HALT);
    chk("fixed_point_stable", int'(stable), 1);
    // simultaneous edges: load wins
    freeze_after = 1000;
    press(1, 0, 0);
    press(1, 1, 1);
    idle(8);
    chk("simul_ctrl", int'(ctrl_state), M_IDLE);
    // counter saturation
    press(1, 0, 0);
    repeat (260) press(0, 0, 1);
    idle(2);
    chk("saturate_gen", int'(gen_count), 255);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) max_gens = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      if ($urandom_range(0, 59) == 0) freeze_after = ($urandom_range(0, 1) == 0) ? 1000 : $urandom_range(0, 6);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
    end
    // asynchronous reset while free-running
    max_gens = 8'd0;
    freeze_after = 1000;
    press(1, 0, 0);
    press(0, 1, 0);
    idle(10);
    chk("run_before_reset", int'(ctrl_state), M_RUN);
    do_reset();
    press(0, 0, 1);
    idle(3);
    chk("gen_after_reset_step", int'(gen_count), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
